// File: rtl/spi_data_buffer.sv
// rtl/spi_data_buffer.sv - TX/RX byte buffers between CPU word bus and SPI engine byte ports (optional SPI_BUF_STATS_EN)
module spi_data_buffer #(
    parameter int DEPTH_BYTES = 256
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        spi_write_enable,
    input  logic [7:0]  spi_write_address,
    input  logic [7:0]  spi_write_data,
    input  logic [7:0]  spi_read_address,
    output logic [7:0]  spi_read_data,
    input  logic        wrb_if_read,
    input  logic        wrb_if_write,
    input  logic [31:0] wrb_if_write_data,
    input  logic [29:0] wrb_if_address,
    output logic [31:0] wrb_if_read_data,
    output logic        wrb_if_access_complete,
    input  logic        rdb_if_read,
    input  logic [29:0] rdb_if_address,
    output logic [31:0] rdb_if_read_data,
    output logic        rdb_if_access_complete
);

    localparam int AW = $clog2(DEPTH_BYTES);

    logic [7:0]    tx_mem_q [DEPTH_BYTES];
    logic [7:0]    rx_mem_q [DEPTH_BYTES];

    logic [31:0]   wrb_byte_addr;
    logic [31:0]   rdb_byte_addr;
    logic [AW-1:0] wrb_base;
    logic [AW-1:0] rdb_base;
    logic [AW-1:0] spi_rd_idx;
    logic [AW-1:0] spi_wr_idx;
    logic [31:0]   tx_word;
    logic [31:0]   rx_word;
    logic [31:0]   rdb_word;

    logic [7:0]    spi_read_data_q,  spi_read_data_d;
    logic [31:0]   wrb_read_data_q,  wrb_read_data_d;
    logic          wrb_complete_q,   wrb_complete_d;
    logic [31:0]   rdb_read_data_q,  rdb_read_data_d;
    logic          rdb_complete_q,   rdb_complete_d;

    // Upper address bits beyond the buffer depth are deliberately ignored (addresses wrap)
    logic          unused_addr_bits;

    // Word addresses become byte bases; truncation to AW bits gives the wrap
    assign wrb_byte_addr    = {wrb_if_address, 2'b00};
    assign rdb_byte_addr    = {rdb_if_address, 2'b00};
    assign wrb_base         = wrb_byte_addr[AW-1:0];
    assign rdb_base         = rdb_byte_addr[AW-1:0];
    assign spi_rd_idx       = spi_read_address[AW-1:0];
    assign spi_wr_idx       = spi_write_address[AW-1:0];
    assign unused_addr_bits = ^{wrb_byte_addr, rdb_byte_addr, spi_read_address, spi_write_address};

    // Little-endian word views of the addressed TX and RX words
    always_comb begin
        tx_word = '0;
        rx_word = '0;
        for (int i = 0; i < 4; i++) begin
            tx_word[8*i +: 8] = tx_mem_q[wrb_base + AW'(i)];
            rx_word[8*i +: 8] = rx_mem_q[rdb_base + AW'(i)];
        end
    end

`ifdef SPI_BUF_STATS_EN
    logic [15:0] rx_byte_count_q, rx_byte_count_d;
    logic        stat_sel;

    // Byte address bit 10 selects the received-byte counter instead of buffer data
    assign stat_sel = rdb_if_address[8];
    assign rdb_word = stat_sel ? {16'h0000, rx_byte_count_q} : rx_word;

    // Saturating counter; a counter read clears it, counting a same-cycle byte as the first
    always_comb begin
        rx_byte_count_d = rx_byte_count_q;
        if (rdb_if_read && stat_sel) begin
            rx_byte_count_d = spi_write_enable ? 16'd1 : 16'd0;
        end else if (spi_write_enable && (rx_byte_count_q != 16'hFFFF)) begin
            rx_byte_count_d = rx_byte_count_q + 16'd1;
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_byte_count_q <= '0;
        end else begin
            rx_byte_count_q <= rx_byte_count_d;
        end
    end
`else
    assign rdb_word = rx_word;
`endif

    // Next-state for output registers; reads sample the arrays before this edge's writes land
    always_comb begin
        spi_read_data_d = tx_mem_q[spi_rd_idx];
        wrb_complete_d  = wrb_if_read | wrb_if_write;
        wrb_read_data_d = wrb_read_data_q;
        if (wrb_if_read && !wrb_if_write) begin
            wrb_read_data_d = tx_word;
        end
        rdb_complete_d  = rdb_if_read;
        rdb_read_data_d = rdb_read_data_q;
        if (rdb_if_read) begin
            rdb_read_data_d = rdb_word;
        end
    end

    // Output registers; reset drops pending completions and read data at once
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            spi_read_data_q <= '0;
            wrb_read_data_q <= '0;
            wrb_complete_q  <= 1'b0;
            rdb_read_data_q <= '0;
            rdb_complete_q  <= 1'b0;
        end else begin
            spi_read_data_q <= spi_read_data_d;
            wrb_read_data_q <= wrb_read_data_d;
            wrb_complete_q  <= wrb_complete_d;
            rdb_read_data_q <= rdb_read_data_d;
            rdb_complete_q  <= rdb_complete_d;
        end
    end

    // Buffer storage, not reset; CPU writes whole words into TX, SPI engine writes bytes into RX
    always_ff @(posedge clk) begin
        if (wrb_if_write) begin
            for (int i = 0; i < 4; i++) begin
                tx_mem_q[wrb_base + AW'(i)] <= wrb_if_write_data[8*i +: 8];
            end
        end
        if (spi_write_enable) begin
            rx_mem_q[spi_wr_idx] <= spi_write_data;
        end
    end

    assign spi_read_data          = spi_read_data_q;
    assign wrb_if_read_data       = wrb_read_data_q;
    assign wrb_if_access_complete = wrb_complete_q;
    assign rdb_if_read_data       = rdb_read_data_q;
    assign rdb_if_access_complete = rdb_complete_q;

endmodule

// File: tb/tb_spi_data_buffer.sv
// tb/tb_spi_data_buffer.sv - scoreboard testbench for spi_data_buffer
module tb_spi_data_buffer;

    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        spi_write_enable;
    logic [7:0]  spi_write_address;
    logic [7:0]  spi_write_data;
    logic [7:0]  spi_read_address;
    logic [7:0]  spi_read_data;
    logic        wrb_if_read;
    logic        wrb_if_write;
    logic [31:0] wrb_if_write_data;
    logic [29:0] wrb_if_address;
    logic [31:0] wrb_if_read_data;
    logic        wrb_if_access_complete;
    logic        rdb_if_read;
    logic [29:0] rdb_if_address;
    logic [31:0] rdb_if_read_data;
    logic        rdb_if_access_complete;

    spi_data_buffer #(.DEPTH_BYTES(DEPTH)) dut (
        .clk                    (clk),
        .reset_n                (reset_n),
        .spi_write_enable       (spi_write_enable),
        .spi_write_address      (spi_write_address),
        .spi_write_data         (spi_write_data),
        .spi_read_address       (spi_read_address),
        .spi_read_data          (spi_read_data),
        .wrb_if_read            (wrb_if_read),
        .wrb_if_write           (wrb_if_write),
        .wrb_if_write_data      (wrb_if_write_data),
        .wrb_if_address         (wrb_if_address),
        .wrb_if_read_data       (wrb_if_read_data),
        .wrb_if_access_complete (wrb_if_access_complete),
        .rdb_if_read            (rdb_if_read),
        .rdb_if_address         (rdb_if_address),
        .rdb_if_read_data       (rdb_if_read_data),
        .rdb_if_access_complete (rdb_if_access_complete)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        bit          is_read;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        int          due;
        logic [7:0]  data;
    } spi_exp_t;

    exp_t       wrb_q[$];
    exp_t       rdb_q[$];
    spi_exp_t   spi_q[$];

    logic [7:0]  tx_m [DEPTH];
    logic [7:0]  rx_m [DEPTH];
    logic [15:0] cnt_m;
    logic [31:0] last_wrb;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit mon_en   = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] tx_word_m(input logic [29:0] a);
        int b;
        b = int'(a % (DEPTH / 4)) * 4;
        return {tx_m[b+3], tx_m[b+2], tx_m[b+1], tx_m[b]};
    endfunction

    function automatic logic [31:0] rx_word_m(input logic [29:0] a);
        int b;
        b = int'(a % (DEPTH / 4)) * 4;
        return {rx_m[b+3], rx_m[b+2], rx_m[b+1], rx_m[b]};
    endfunction

    // One cycle of stimulus; expectations come from the model before this cycle's writes apply
    task automatic step(input bit wr, input bit rd, input logic [29:0] waddr, input logic [31:0] wdata,
                        input bit rrd, input logic [29:0] raddr,
                        input bit swe, input logic [7:0] swa, input logic [7:0] swd,
                        input logic [7:0] sra, input bit chk_spi);
        exp_t     e;
        spi_exp_t s;
        int       b;
        @(posedge clk);
        #1;
        wrb_if_write      = wr;
        wrb_if_read       = rd;
        wrb_if_address    = waddr;
        wrb_if_write_data = wdata;
        rdb_if_read       = rrd;
        rdb_if_address    = raddr;
        spi_write_enable  = swe;
        spi_write_address = swa;
        spi_write_data    = swd;
        spi_read_address  = sra;
        if (chk_spi) begin
            s.due  = cyc + 1;
            s.data = tx_m[sra];
            spi_q.push_back(s);
        end
        if (wr || rd) begin
            e.due     = cyc + 1;
            e.is_read = !wr;
            e.data    = tx_word_m(waddr);
            wrb_q.push_back(e);
        end
        if (rrd) begin
            e.due     = cyc + 1;
            e.is_read = 1'b1;
            e.data    = rx_word_m(raddr);
`ifdef SPI_BUF_STATS_EN
            if (raddr[8]) e.data = {16'h0000, cnt_m};
`endif
            rdb_q.push_back(e);
        end
        if (wr) begin
            b = int'(waddr % (DEPTH / 4)) * 4;
            for (int i = 0; i < 4; i++) tx_m[b+i] = wdata[8*i +: 8];
        end
        if (swe) rx_m[swa] = swd;
`ifdef SPI_BUF_STATS_EN
        if (rrd && raddr[8]) cnt_m = swe ? 16'd1 : 16'd0;
        else if (swe && cnt_m != 16'hFFFF) cnt_m = cnt_m + 16'd1;
`endif
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Scoreboard: each expected completion must appear exactly in its due cycle and nowhere else
    always @(negedge clk) begin : mon
        exp_t     e;
        spi_exp_t s;
        bit       exp_c;
        if (mon_en) begin
            exp_c = (wrb_q.size() > 0) && (wrb_q[0].due == cyc);
            if (exp_c || wrb_if_access_complete) begin
                check_eq("wrb_complete", {31'h0, wrb_if_access_complete}, {31'h0, exp_c});
                if (exp_c) begin
                    e = wrb_q.pop_front();
                    if (e.is_read) begin
                        check_eq("wrb_rdata", wrb_if_read_data, e.data);
                        last_wrb = e.data;
                    end else begin
                        check_eq("wrb_rdata_hold", wrb_if_read_data, last_wrb);
                    end
                end
            end
            exp_c = (rdb_q.size() > 0) && (rdb_q[0].due == cyc);
            if (exp_c || rdb_if_access_complete) begin
                check_eq("rdb_complete", {31'h0, rdb_if_access_complete}, {31'h0, exp_c});
                if (exp_c) begin
                    e = rdb_q.pop_front();
                    check_eq("rdb_rdata", rdb_if_read_data, e.data);
                end
            end
            if ((spi_q.size() > 0) && (spi_q[0].due == cyc)) begin
                s = spi_q.pop_front();
                check_eq("spi_rdata", {24'h0, spi_read_data}, {24'h0, s.data});
            end
        end
    end

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_spi_rdata"}, {24'h0, spi_read_data}, 32'h0);
        check_eq({tag, "_wrb_rdata"}, wrb_if_read_data, 32'h0);
        check_eq({tag, "_wrb_cmpl"}, {31'h0, wrb_if_access_complete}, 32'h0);
        check_eq({tag, "_rdb_rdata"}, rdb_if_read_data, 32'h0);
        check_eq({tag, "_rdb_cmpl"}, {31'h0, rdb_if_access_complete}, 32'h0);
    endtask

    initial begin
        reset_n           = 1'b0;
        spi_write_enable  = 1'b0;
        spi_write_address = '0;
        spi_write_data    = '0;
        spi_read_address  = '0;
        wrb_if_read       = 1'b0;
        wrb_if_write      = 1'b0;
        wrb_if_write_data = '0;
        wrb_if_address    = '0;
        rdb_if_read       = 1'b0;
        rdb_if_address    = '0;
        cnt_m             = '0;
        last_wrb          = '0;
        for (int i = 0; i < DEPTH; i++) begin
            tx_m[i] = 'x;
            rx_m[i] = 'x;
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_outputs_zero("reset");
        @(posedge clk);
        #1 reset_n = 1'b1;
        mon_en = 1'b1;

        // 1: word write, then byte fetches in little-endian order
        step(1, 0, 30'h0, 32'hDDCCBBAA, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 8'(i), 1);

        // 2: RX bytes 4..7 then word read
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 1, 8'(4 + i), 8'(8'h11 * (i + 1)), 0, 0);
        step(0, 0, 0, 0, 1, 30'h1, 0, 0, 0, 0, 0);
        idle(1);

        // 3: wrapping word addresses
        step(1, 0, 30'h41, 32'h12345678, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h04, 1);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 1, 8'(i), 8'(8'hA0 + i), 0, 0);
        step(0, 0, 0, 0, 1, 30'h40, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 30'h00, 0, 0, 0, 0, 0);
        step(0, 1, 30'h3FFF_FF41, 0, 0, 0, 0, 0, 0, 0, 0);

        // 4: read-before-write collision on RX byte 8
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 1, 8'(8 + i), 8'(8'h55 + 8'h10 * i), 0, 0);
        step(0, 0, 0, 0, 1, 30'h2, 1, 8'h08, 8'h66, 0, 0);
        step(0, 0, 0, 0, 1, 30'h2, 0, 0, 0, 0, 0);

        // TX collision: fetch of byte 4 while the CPU overwrites it
        step(1, 0, 30'h1, 32'hAABBCCDD, 0, 0, 0, 0, 0, 8'h04, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h04, 1);

        // 5: back-to-back reads, then simultaneous wrb read+write
        step(0, 0, 0, 0, 1, 30'h0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 30'h1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 30'h2, 0, 0, 0, 0, 0);
        step(1, 1, 30'h3, 32'hCAFEF00D, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 30'h3, 0, 0, 0, 0, 0, 0, 8'h0C, 1);
        step(0, 1, 30'h0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 30'h5, 32'h0BADBEEF, 0, 0, 0, 0, 0, 0, 0);
        idle(1);

        // Randomised traffic over a small, fully initialised window
        for (int i = 0; i < 32; i++)
            step(i < 8, 0, 30'(i), $urandom, 0, 0, 1, 8'(i), 8'($urandom), 0, 0);
        for (int i = 0; i < 300; i++) begin
            logic [29:0] wa, ra;
            bit          wr, rd, rr, sw;
            wa = 30'($urandom_range(0, 7) + 64 * $urandom_range(0, 3));
            ra = 30'($urandom_range(0, 7) + 64 * $urandom_range(0, 3) + 256 * $urandom_range(0, 1));
            wr = ($urandom_range(0, 3) == 0);
            rd = ($urandom_range(0, 2) == 0);
            rr = ($urandom_range(0, 1) == 0);
            sw = ($urandom_range(0, 1) == 0);
            step(wr, rd, wa, $urandom, rr, ra, sw, 8'($urandom_range(0, 31)), 8'($urandom),
                 8'($urandom_range(0, 31)), 1);
        end
        idle(2);

        // 6: reset while a wrb read completion is pending
        step(0, 1, 30'h0, 0, 0, 0, 0, 0, 0, 0, 0);
        wrb_q.delete();
        @(posedge clk);
        #1;
        wrb_if_read = 1'b0;
        reset_n     = 1'b0;
        @(negedge clk);
        check_outputs_zero("midreset");
        @(posedge clk);
        #1;
        reset_n  = 1'b1;
        last_wrb = '0;
        cnt_m    = '0;
        @(negedge clk);
        check_eq("post_reset_wrb_cmpl", {31'h0, wrb_if_access_complete}, 32'h0);
        check_eq("post_reset_wrb_rdata", wrb_if_read_data, 32'h0);

`ifdef SPI_BUF_STATS_EN
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 0, 1, 8'(40 + i), 8'(i), 0, 0);
        step(0, 0, 0, 0, 1, 30'h100, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 30'h100, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 30'h3FFF_FF00, 1, 8'd50, 8'h1, 0, 0);
        step(0, 0, 0, 0, 1, 30'h100, 0, 0, 0, 0, 0);
`endif
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
